// File: rtl/hazard_unit.sv
// hazard_unit -- pipeline hazard unit for the five-stage ARM core.
//
// Purpose: resolves data hazards by forwarding and load-use stalls, handles
// PC redirects by flushing, and freezes the whole pipeline while a
// multi-cycle data-memory access is outstanding. A wait counter guards each
// access; if memory never answers, the unit locks into an error state that
// keeps the pipeline frozen until reset.
//
// Optional build macro: HAZARD_PERFCNT_EN adds stall/flush cycle counters.
// Without it, StallCycles/FlushCycles are constant zero and no counter flops
// are built.
//
// Ports:
//   clk, reset                 rising-edge clock, async active-low reset
//   RA1D/RA2D, RA1E/RA2E       source register numbers in Decode / Execute
//   WA3E/WA3M/WA3W             destination register numbers in E / M / W
//   RegWriteM/W, MemtoRegE     writeback enables, Execute-is-load
//   MemReqM, MemReadyM         data-memory request / completion in Memory
//   PCWrPendingF, PCSrcW,
//   BranchTakenD               PC redirect status from the controller
//   ForwardAE/BE               00 regfile, 01 ResultW, 10 ALUOutM
//   StallF/D/E/M               hold stage registers
//   FlushD/E/W                 clear stage registers to bubbles
//   MemErr                     sticky memory-timeout flag
//   StallCycles, FlushCycles   performance counters
module hazard_unit #(
    parameter int WAIT_W      = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  RA1D,
    input  logic [3:0]  RA2D,
    input  logic [3:0]  RA1E,
    input  logic [3:0]  RA2E,
    input  logic [3:0]  WA3E,
    input  logic [3:0]  WA3M,
    input  logic [3:0]  WA3W,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        MemtoRegE,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    input  logic        PCWrPendingF,
    input  logic        PCSrcW,
    input  logic        BranchTakenD,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic        MemErr,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushCycles
);

    typedef enum logic [1:0] {
        MS_RUN  = 2'd0,
        MS_WAIT = 2'd1,
        MS_ERR  = 2'd2
    } memState_t;

    memState_t         state, stateNext;
    logic [WAIT_W-1:0] waitCnt, waitCntNext;
    logic              memStall;
    logic              ldrStall;

    // Memory stage result beats writeback result: it is the younger write.
    function automatic logic [1:0] fwdSel(
        input logic [3:0] ra,
        input logic       regWrM,
        input logic [3:0] waM,
        input logic       regWrW,
        input logic [3:0] waW
    );
        if (regWrM && (ra == waM))      return 2'b10;
        else if (regWrW && (ra == waW)) return 2'b01;
        else                            return 2'b00;
    endfunction

    assign ForwardAE = fwdSel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
    assign ForwardBE = fwdSel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);

    assign ldrStall = MemtoRegE & ((RA1D == WA3E) | (RA2D == WA3E));

    // ---------------- memory wait FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= MS_RUN;
            waitCnt <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
        end
    end

    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        memStall    = 1'b0;
        unique case (state)
            MS_RUN: begin
                // Ready in the request cycle is a zero-wait access.
                memStall = MemReqM & ~MemReadyM;
                if (MemReqM && !MemReadyM) begin
                    stateNext   = MS_WAIT;
                    waitCntNext = WAIT_W'(1);
                end
            end
            MS_WAIT: begin
                memStall = ~MemReadyM;
                if (MemReadyM) begin
                    stateNext   = MS_RUN;
                    waitCntNext = '0;
                end else if (waitCnt == WAIT_W'(MEM_TIMEOUT)) begin
                    stateNext = MS_ERR;
                end else begin
                    waitCntNext = waitCnt + WAIT_W'(1);
                end
            end
            MS_ERR: begin
                // Terminal: late ready responses are ignored.
                memStall = 1'b1;
            end
            default: begin
                stateNext   = MS_RUN;
                waitCntNext = '0;
            end
        endcase
    end

    // ERR is only left through reset, so the state itself is the sticky flag.
    assign MemErr = (state == MS_ERR);

    // ---------------- stall / flush ----------------
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (memStall) begin
            // Freeze F..M and bubble W; redirect flushes wait until the
            // freeze lifts so no in-flight instruction is lost.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = ldrStall | PCWrPendingF;
            StallD = ldrStall;
            FlushD = PCWrPendingF | PCSrcW | BranchTakenD;
            FlushE = ldrStall | BranchTakenD;
        end
    end

    // ---------------- performance counters ----------------
`ifdef HAZARD_PERFCNT_EN
    logic [31:0] stallCnt, flushCnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            stallCnt <= stallCnt + {31'd0, StallF};
            flushCnt <= flushCnt + {31'd0, FlushD | FlushE};
        end
    end

    assign StallCycles = stallCnt;
    assign FlushCycles = flushCnt;
`else
    assign StallCycles = '0;
    assign FlushCycles = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: the stimulus process drives one input
// vector per cycle, computes the expected outputs from a behavioural model
// and queues them; a monitor on the falling edge pops and compares.
module tb_hazard_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic        RegWriteM, RegWriteW, MemtoRegE, MemReqM, MemReadyM;
    logic        PCWrPendingF, PCSrcW, BranchTakenD;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
    logic [31:0] StallCycles, FlushCycles;

    hazard_unit #(.WAIT_W(8), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW), .BranchTakenD(BranchTakenD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemErr(MemErr),
        .StallCycles(StallCycles), .FlushCycles(FlushCycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [3:0]  stall;   // F D E M
        logic [2:0]  flush;   // D E W
        logic        err;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cycleNo = 0;

    // Model state: consecutive not-ready cycles of the open access, error flag,
    // and running counter totals.
    int          pend;
    bit          err;
    logic [31:0] sc, fc;

    function automatic logic [1:0] mFwd(input logic [3:0] ra);
        if (RegWriteM && ra == WA3M) return 2'b10;
        if (RegWriteW && ra == WA3W) return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cycleNo, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("forward", {28'd0, ForwardAE, ForwardBE}, {28'd0, e.fa, e.fb});
            chk("stall", {28'd0, StallF, StallD, StallE, StallM}, {28'd0, e.stall});
            chk("flush", {29'd0, FlushD, FlushE, FlushW}, {29'd0, e.flush});
            chk("memerr", {31'd0, MemErr}, {31'd0, e.err});
`ifdef HAZARD_PERFCNT_EN
            chk("stallcycles", StallCycles, e.sc);
            chk("flushcycles", FlushCycles, e.fc);
`else
            chk("stallcycles", StallCycles, 32'd0);
            chk("flushcycles", FlushCycles, 32'd0);
`endif
            cycleNo++;
        end
    end

    task automatic clr();
        {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
        {RegWriteM, RegWriteW, MemtoRegE, MemReqM, MemReadyM} = '0;
        {PCWrPendingF, PCSrcW, BranchTakenD} = '0;
    endtask

    task automatic rnd();
        RA1D = 4'($urandom_range(3)); RA2D = 4'($urandom_range(3));
        RA1E = 4'($urandom_range(3)); RA2E = 4'($urandom_range(3));
        WA3E = 4'($urandom_range(3)); WA3M = 4'($urandom_range(3));
        WA3W = 4'($urandom_range(3));
        RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
        MemtoRegE = 1'($urandom); MemReqM = ($urandom_range(2) == 0);
        MemReadyM = 1'($urandom);
        PCWrPendingF = ($urandom_range(3) == 0); PCSrcW = ($urandom_range(3) == 0);
        BranchTakenD = ($urandom_range(3) == 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply the current inputs for this cycle (rst=0 holds reset low).
    task automatic eval(input bit rst);
        exp_t e;
        bit ldr, open, ms, sF, fD, fE;
        reset = rst;
        if (!rst) begin
            pend = 0; err = 0; sc = '0; fc = '0;
        end
        ldr  = MemtoRegE && (RA1D == WA3E || RA2D == WA3E);
        open = MemReqM || pend > 0;
        ms   = err || (open && !MemReadyM);
        sF   = ms ? 1'b1 : (ldr || PCWrPendingF);
        fD   = ms ? 1'b0 : (PCWrPendingF || PCSrcW || BranchTakenD);
        fE   = ms ? 1'b0 : (ldr || BranchTakenD);
        e.fa = mFwd(RA1E);
        e.fb = mFwd(RA2E);
        e.stall = {sF, ms ? 1'b1 : ldr, ms, ms};
        e.flush = {fD, fE, ms};
        e.err = err;
        e.sc = sc;
        e.fc = fc;
        q.push_back(e);
        if (rst) begin
            sc = sc + {31'd0, sF};
            fc = fc + {31'd0, fD | fE};
            if (!err) begin
                if (open && !MemReadyM) begin
                    pend++;
                    if (pend == TO + 1) err = 1;
                end else begin
                    pend = 0;
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        clr();
        pend = 0; err = 0; sc = '0; fc = '0;
        tick(); eval(0);
        tick(); eval(0);

        // Forward priority.
        tick(); clr(); RegWriteM = 1; RegWriteW = 1; WA3M = 3; WA3W = 3; RA1E = 3; eval(1);
        tick(); RegWriteM = 0; eval(1);
        tick(); RA1E = 4; eval(1);
        // Load-use, then released.
        tick(); clr(); MemtoRegE = 1; WA3E = 5; RA2D = 5; eval(1);
        tick(); MemtoRegE = 0; eval(1);
        // Branch; PC write pending alone.
        tick(); clr(); BranchTakenD = 1; eval(1);
        tick(); clr(); PCWrPendingF = 1; eval(1);
        // Memory wait of three cycles with a concurrent branch.
        for (int i = 0; i < 4; i++) begin
            tick(); clr(); MemReqM = 1; BranchTakenD = 1; MemReadyM = (i == 3); eval(1);
        end
        tick(); clr(); eval(1);
        // Zero-wait access.
        tick(); clr(); MemReqM = 1; MemReadyM = 1; eval(1);
        // Timeout into ERR, late ready ignored, reset mid-ERR.
        for (int i = 0; i < 9; i++) begin
            tick(); clr(); MemReqM = 1; MemReadyM = (i >= 6); eval(1);
        end
        tick(); clr(); eval(0);
        // Counter scenario: two load-use cycles plus one branch cycle.
        tick(); clr(); MemtoRegE = 1; WA3E = 5; RA1D = 5; eval(1);
        tick(); eval(1);
        tick(); clr(); BranchTakenD = 1; eval(1);
        tick(); clr(); eval(1);

        // Randomized phase with occasional resets (more likely once in ERR).
        for (int i = 0; i < 3000; i++) begin
            tick(); rnd();
            eval(!(($urandom_range(80) == 0) || (err && $urandom_range(4) == 0)));
        end

        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard unit for the five-stage ARM core. It consumes the controller's per-stage control outputs (RegWriteM/W, MemtoRegE, PCSrcW, BranchTakenD, PCWrPendingF) and the datapath register addresses. It drives forwarding selects, stage stalls and flushes, including the FlushE the controller consumes. It also owns a data-memory wait state machine with a timeout, so multi-cycle memory freezes the pipeline cleanly.

## Interface
Parameters:
- WAIT_W, 8: width of memory wait counter.
- MEM_TIMEOUT, 200: wait cycles without MemReadyM before error; must be < 2^WAIT_W.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- RA1D, RA2D  in  4  source registers in Decode.
- RA1E, RA2E  in  4  source registers in Execute.
- WA3E, WA3M, WA3W  in  4  destination register in E/M/W.
- RegWriteM, RegWriteW  in  1  destination write enables (already condition-gated).
- MemtoRegE  in  1  Execute instruction is a load.
- MemReqM  in  1  Memory-stage instruction accesses data memory.
- MemReadyM  in  1  data memory completes access this cycle.
- PCWrPendingF, PCSrcW, BranchTakenD  in  1  PC-redirect status from controller.
- ForwardAE, ForwardBE  out  2  SrcA/SrcB select: 00 regfile, 01 ResultW, 10 ALUOutM.
- StallF, StallD, StallE, StallM  out  1  hold stage register.
- FlushD, FlushE, FlushW  out  1  clear stage register to bubble.
- MemErr  out  1  sticky memory timeout flag.
- StallCycles, FlushCycles  out  32  performance counters (see Configuration).

## Operation
- Forwarding (per operand X in {1,2}): if RegWriteM & RA{X}E==WA3M -> 10; else if RegWriteW & RA{X}E==WA3W -> 01; else 00. M has priority over W. R15 is not special-cased.
- LdrStall = MemtoRegE & (RA1D==WA3E | RA2D==WA3E).
- MemStall = (state RUN & MemReqM & ~MemReadyM) | (state WAIT & ~MemReadyM) | state ERR.
- With MemStall=0:
  - StallF = LdrStall | PCWrPendingF.
  - StallD = LdrStall.
  - FlushD = PCWrPendingF | PCSrcW | BranchTakenD.
  - FlushE = LdrStall | BranchTakenD.
  - StallE = StallM = FlushW = 0.
- With MemStall=1:
  - StallF = StallD = StallE = StallM = 1, FlushW = 1.
  - FlushD = FlushE = 0.
  - Memory stall overrides all other hazards.
- FSM states:
  - RUN -> WAIT when MemReqM & ~MemReadyM. WaitCnt <= 1.
  - WAIT -> RUN when MemReadyM. WaitCnt <= 0.
  - WAIT -> ERR when ~MemReadyM & WaitCnt == MEM_TIMEOUT. Otherwise WaitCnt increments.
  - ERR: terminal until reset. MemErr=1, pipeline frozen.
- Reset (asynchronous, mid-operation included): state RUN, WaitCnt 0, MemErr 0, counters 0. Outputs then follow the combinational rules above for state RUN.

## Timing
- Forward, stall and flush outputs are combinational from inputs and current state: same-cycle response, zero latency.
- State, WaitCnt, MemErr and counters update on the rising clk edge.
- MemReadyM in the same cycle as a new MemReqM in RUN: no stall, state stays RUN.
- Access completing after N wait cycles: MemStall high for N cycles. It drops combinationally in the cycle MemReadyM=1.
- ERR is entered on the edge after the cycle where WaitCnt==MEM_TIMEOUT with no ready. MemErr rises the cycle after that edge.
- MemReadyM while in ERR is ignored.

## Configuration
- HAZARD_PERFCNT_EN defined:
  - StallCycles increments every cycle StallF=1.
  - FlushCycles increments every cycle FlushD|FlushE=1.
  - Both are 32-bit, wrap modulo 2^32, and are cleared by reset.
- HAZARD_PERFCNT_EN undefined: no counter flops; StallCycles and FlushCycles are tied to 0.

## Test plan
- Forward priority: RegWriteM=RegWriteW=1, WA3M=WA3W=RA1E=3 -> ForwardAE=10. Drop RegWriteM -> 01. RA1E=4 -> 00.
- Load-use: MemtoRegE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1, FlushD=0. MemtoRegE=0 -> all 0.
- Branch: BranchTakenD=1 -> FlushD=FlushE=1, StallF=0. PCWrPendingF=1 alone -> StallF=FlushD=1.
- Memory wait: MemReqM=1, MemReadyM low 3 cycles then high -> StallF..StallM=FlushW=1 for exactly 3 cycles, FlushE forced 0 even with BranchTakenD=1, state returns to RUN.
- Timeout: MEM_TIMEOUT=4, MemReadyM held 0 -> ERR entered, MemErr=1, all stalls stay 1 after MemReadyM=1. Reset low mid-ERR -> MemErr=0, RUN.
- Counters (macro on): 2 load-use cycles plus 1 branch cycle -> StallCycles=2, FlushCycles=3. Macro off -> both read 0.
